ahb_wait_sram_slave: RTL and testbench

AHB_WAIT_SRAM_SLAVE -- requirements
Module: ahb_wait_sram_slave

---
 rtl/ahb_wait_sram_slave.sv | 146 ++++++++++++++
 tb/tb_ahb_wait_sram_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_wait_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states.
// Misaligned or oversized transfers answer with a two-cycle ERROR.
module ahb_wait_sram_slave #(
  parameter int WAIT_STATES = 1,
  parameter int MEM_WORDS   = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int AW =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [2:0] WS3 = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_pend;
  logic [7:0]    r_addr;
  logic          r_write;
  logic [2:0]    r_size;
  logic          r_ready;
  logic          r_resp;
  logic [31:0]   r_mem [MEM_WORDS];

  logic          w_acc;
  logic          w_bad;
  logic          w_done;
  logic          w_rd;
  logic [3:0]    w_be;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_unused = &{1'b0, HBURST, HADDR[31:8]};

  // Only sample a new address phase while our own data phase is ready.
  assign w_acc = HSEL & HREADY & HTRANS[1] & r_ready;

  assign w_bad = (HSIZE > 3'd2)
    | ((HSIZE == 3'd1) & HADDR[0])
    | ((HSIZE == 3'd2) & (|HADDR[1:0]));

  assign w_done = r_pend & (r_state == S_IDLE);
  assign w_rd   = w_done & ~r_write;
  assign w_idx  = r_addr[AW+1:2];

  assign HREADYOUT = r_ready;
  assign HRESP     = r_resp;
  assign HRDATA    = w_rd ? r_mem[w_idx] : '0;

  // Byte-lane enables for the latched size and address.
  always_comb begin
    w_be = 4'b1111;
    unique case (r_size)
      3'd0:    w_be = 4'b0001 << r_addr[1:0];
      3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Transfer FSM with registered ready/response.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_ready <= 1'b1;
      r_resp  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_ERR2: begin
          r_state <= S_IDLE;
          r_pend  <= 1'b0;
          r_ready <= 1'b1;
          r_resp  <= 1'b0;
          if (w_acc) begin
            r_addr  <= HADDR[7:0];
            r_write <= HWRITE;
            r_size  <= HSIZE;
            if (w_bad) begin
              r_state <= S_ERR1;
              r_ready <= 1'b0;
              r_resp  <= 1'b1;
            end else if (WS3 != 3'd0) begin
              r_state <= S_WAIT;
              r_cnt   <= WS3;
              r_pend  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_pend  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt   <= r_cnt - 3'd1;
          end
        end
        S_ERR1: begin
          r_state <= S_ERR2;
          r_ready <= 1'b1;
          r_resp  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Lane-masked write at the end of a write completion cycle.
  always_ff @(posedge HCLK) begin
    if (w_done & r_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_wait_sram_slave.sv
// Bench for ahb_wait_sram_slave: one DUT with one wait
// state and one with none, checked against a byte-level model.
module tb_ahb_wait_sram_slave;

  localparam logic [1:0] IDL = 2'd0;
  localparam logic [1:0] BSY = 2'd1;
  localparam logic [1:0] NSQ = 2'd2;
  localparam logic [1:0] SQ  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b1;
  logic        HSEL = 1'b0;
  logic        HWRITE = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [2:0]  HSIZE = '0;
  logic [2:0]  HBURST = '0;
  logic [1:0]  HTRANS = '0;

  logic        rdy1, rdy0, resp1, resp0;
  logic [31:0] rd1, rd0;
  logic        hsel1, hsel0;
  logic        HREADY, resp_act;
  logic [31:0] rd_act;

  assign hsel1    = HSEL & sel;
  assign hsel0    = HSEL & ~sel;
  assign HREADY   = sel ? rdy1 : rdy0;
  assign resp_act = sel ? resp1 : resp0;
  assign rd_act   = sel ? rd1 : rd0;

  always #5 clk = ~clk;

  ahb_wait_sram_slave #(
    .WAIT_STATES(1), .MEM_WORDS(64)
  ) u1 (
    .HCLK(clk), .HRESETn(rst_n),
    .HSEL(hsel1), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HREADY(rdy1),
    .HRDATA(rd1), .HREADYOUT(rdy1),
    .HRESP(resp1)
  );

  ahb_wait_sram_slave #(
    .WAIT_STATES(0), .MEM_WORDS(64)
  ) u0 (
    .HCLK(clk), .HRESETn(rst_n),
    .HSEL(hsel0), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HREADY(rdy0),
    .HRDATA(rd0), .HREADYOUT(rdy0),
    .HRESP(resp0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: current data phase of the selected slave
  // (0 none, 1 okay, 2 error) plus byte-wide memory image.
  int          ph_kind = 0;
  int          ph_wait = 0;
  int          ph_step = 0;
  logic [7:0]  ph_addr = '0;
  logic        ph_wr = 1'b0;
  logic [2:0]  ph_size = '0;
  logic [7:0]  mm [2][256];
  bit          kn [2][256];

  task automatic exp_out(output logic r, output logic e,
                         output logic [31:0] d,
                         output bit dk);
    int base;
    r = 1'b1; e = 1'b0; d = '0; dk = 1'b1;
    if (ph_kind == 1) begin
      if (ph_wait > 0) begin
        r = 1'b0;
      end else if (!ph_wr) begin
        base = int'(ph_addr) / 4 * 4;
        for (int b = 0; b < 4; b++) begin
          d[8*b +: 8] = mm[sel][base+b];
          if (!kn[sel][base+b]) dk = 1'b0;
        end
      end
    end else if (ph_kind == 2) begin
      e = 1'b1;
      r = (ph_step == 1);
    end
  endtask

  task automatic model_step();
    int  base;
    int  a;
    int  sz;
    bit  en;
    if (!rst_n) begin
      ph_kind = 0;
      return;
    end
    if (ph_kind == 1 && ph_wait > 0) begin
      ph_wait--;
    end else if (ph_kind == 2 && ph_step == 0) begin
      ph_step = 1;
    end else begin
      if (ph_kind == 1 && ph_wr) begin
        base = int'(ph_addr) / 4 * 4;
        a = int'(ph_addr) % 4;
        for (int b = 0; b < 4; b++) begin
          en = (ph_size == 3'd2)
            || (ph_size == 3'd1 && b / 2 == a / 2)
            || (ph_size == 3'd0 && b == a);
          if (en) begin
            mm[sel][base+b] = HWDATA[8*b +: 8];
            kn[sel][base+b] = 1'b1;
          end
        end
      end
      ph_kind = 0;
      if (HSEL && HTRANS[1]) begin
        ph_addr = HADDR[7:0];
        ph_wr   = HWRITE;
        ph_size = HSIZE;
        a  = int'(HADDR[7:0]);
        sz = int'(HSIZE);
        if (sz > 2 || (sz == 1 && a % 2 != 0)
            || (sz == 2 && a % 4 != 0)) begin
          ph_kind = 2;
          ph_step = 0;
        end else begin
          ph_kind = 1;
          ph_wait = sel ? 1 : 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial begin : cmp
    logic er, ee;
    logic [31:0] ed;
    bit edk;
    forever begin
      @(negedge clk);
      exp_out(er, ee, ed, edk);
      check("hreadyout", 32'(HREADY), 32'(er));
      check("hresp", 32'(resp_act), 32'(ee));
      if (edk) check("hrdata", rd_act, ed);
      check("other_rdy",
            32'(sel ? rdy0 : rdy1), 32'd1);
      check("other_rdata",
            sel ? rd0 : rd1, 32'd0);
    end
  end

  int          nwait;
  logic        low_resp;
  logic [31:0] cap_rd;
  logic        cap_resp;

  task automatic xfer(input logic hs,
                      input logic [1:0] t,
                      input logic [31:0] a,
                      input logic w,
                      input logic [2:0] s,
                      input logic [2:0] b,
                      input logic [31:0] d);
    int k;
    logic rr;
    HSEL = hs; HTRANS = t; HADDR = a;
    HWRITE = w; HSIZE = s; HBURST = b;
    nwait = 0; low_resp = 1'b0; k = 0;
    do begin
      @(negedge clk);
      rr = HREADY;
      if (!rr) begin
        nwait++;
        low_resp = low_resp | resp_act;
      end else begin
        cap_rd = rd_act;
        cap_resp = resp_act;
      end
      @(posedge clk);
      k++;
    end while (!rr && k < 16);
    if (!rr) begin
      n_cmp++;
      n_bad++;
      $display("FAIL xfer_timeout: HREADY low %0d cycles", k);
    end
    #1;
    HWDATA = d;
  endtask

  task automatic idle();
    xfer(1'b1, IDL, 32'h0, 1'b0, 3'd0, 3'd0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [2:0] s,
                    input logic [31:0] d);
    xfer(1'b1, NSQ, a, 1'b1, s, 3'd0, d);
  endtask

  task automatic rd(input logic [31:0] a);
    xfer(1'b1, NSQ, a, 1'b0, 3'd2, 3'd0, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1;
    logic [31:0] v;
    #1 rst_n = 1'b0;
    #2;
    check("rst_rdy1", 32'(rdy1), 32'd1);
    check("rst_resp1", 32'(resp1), 32'd0);
    check("rst_rdata1", rd1, 32'd0);
    check("rst_rdy0", 32'(rdy0), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // one wait state: basic word write then read
    wr(32'h10, 3'd2, 32'hDEADBEEF);
    check("first_accept", 32'(nwait), 32'd0);
    rd(32'h10);
    check("wr_wait", 32'(nwait), 32'd1);
    check("wr_resp", 32'(cap_resp), 32'd0);
    idle();
    check("rd_wait", 32'(nwait), 32'd1);
    check("rd10", cap_rd, 32'hDEADBEEF);

    // byte lane 1 over a zero word
    wr(32'h10, 3'd2, 32'h0);
    wr(32'h11, 3'd0, 32'h0000AA00);
    rd(32'h10);
    idle();
    check("byte_rd", cap_rd, 32'h0000AA00);

    // misaligned halfword read
    xfer(1'b1, NSQ, 32'h13, 1'b0, 3'd1, 3'd0, 32'h0);
    idle();
    check("err_low", 32'(nwait), 32'd1);
    check("err_low_resp", 32'(low_resp), 32'd1);
    check("err2_resp", 32'(cap_resp), 32'd1);
    check("err_rdata", cap_rd, 32'd0);
    rd(32'h10);
    idle();
    check("err_nochg", cap_rd, 32'h0000AA00);

    // halfword write, oversize write, read taken in ERR2
    wr(32'h12, 3'd1, 32'hBEEF0000);
    wr(32'h10, 3'd3, 32'hFFFFFFFF);
    rd(32'h10);
    check("err1_before_rd", 32'(nwait), 32'd1);
    check("err2_before_rd", 32'(cap_resp), 32'd1);
    idle();
    check("half_rd", cap_rd, 32'hBEEF_AA00);

    // BUSY inside an INCR burst
    xfer(1'b1, NSQ, 32'h40, 1'b1, 3'd2, 3'd1,
         32'h11112222);
    xfer(1'b1, BSY, 32'h44, 1'b1, 3'd2, 3'd1, 32'h0);
    xfer(1'b1, SQ, 32'h44, 1'b1, 3'd2, 3'd1,
         32'h33334444);
    check("busy_zero_wait", 32'(nwait), 32'd0);
    check("busy_resp", 32'(cap_resp), 32'd0);
    rd(32'h44);
    rd(32'h40);
    check("rd44", cap_rd, 32'h33334444);
    idle();
    check("rd40", cap_rd, 32'h11112222);

    // reset during the wait state of a write
    wr(32'h30, 3'd2, 32'hCAFEF00D);
    wr(32'h30, 3'd2, 32'h0BADBEEF);
    HSEL = 1'b0;
    HTRANS = IDL;
    #2;
    check("pre_rst_rdy", 32'(HREADY), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_rdy", 32'(HREADY), 32'd1);
    check("rst_async_resp", 32'(resp_act), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(32'h30);
    check("post_rst_accept", 32'(nwait), 32'd0);
    idle();
    check("rst_abort_wr", cap_rd, 32'hCAFEF00D);

    // zero wait states: INCR4 writes then reads
    sel = 1'b0;
    t1 = $time;
    for (int i = 0; i < 4; i++) begin
      v = 32'hA0000000 + 32'(i) * 32'h1111;
      xfer(1'b1, (i == 0) ? NSQ : SQ,
           32'h20 + 32'(4 * i), 1'b1, 3'd2, 3'd3, v);
      check("ws0_wr_wait", 32'(nwait), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, (i == 0) ? NSQ : SQ,
           32'h20 + 32'(4 * i), 1'b0, 3'd2, 3'd3, 32'h0);
      check("ws0_rd_wait", 32'(nwait), 32'd0);
      if (i > 0) begin
        v = 32'hA0000000 + 32'(i - 1) * 32'h1111;
        check("ws0_rd", cap_rd, v);
      end
    end
    idle();
    check("ws0_rd3", cap_rd, 32'hA0003333);
    check("ws0_cycles", 32'($time - t1), 32'd90);

    // zero wait states: write then read same word
    wr(32'h50, 3'd2, 32'h5A5AA5A5);
    rd(32'h50);
    idle();
    check("raw_rd", cap_rd, 32'h5A5AA5A5);
    wr(32'h53, 3'd0, 32'h77000000);
    rd(32'h50);
    idle();
    check("raw_byte", cap_rd, 32'h775AA5A5);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
